// File: rtl/dmem_banked_rw.sv
// Byte-addressed data memory with sized little-endian accesses, wait states and a req/ready/resp_valid handshake.
// Optional build macro DMEM_CLEAR_ON_RESET_EN zeroes all memory bytes while RST_N is low.
module dmem_banked_rw #(
    parameter int DATA_WID    = 64,
    parameter int DEPTH       = 1024,
    parameter int ADDR_WID    = 64,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                req,
    input  logic                we,
    input  logic [1:0]          size,
    input  logic [ADDR_WID-1:0] addr,
    input  logic [DATA_WID-1:0] write_data,
    output logic                ready,
    output logic                resp_valid,
    output logic [DATA_WID-1:0] rdata,
    output logic                dmem_error,
    output logic [1:0]          fsm_state
);
    // Handshake: a request is taken on a rising edge where req && ready; the
    // result is presented for exactly one cycle while resp_valid is high.
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

    localparam int IDX_WID = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] MAX_BYTES = 4'(DATA_WID / 8);
    localparam logic [ADDR_WID:0] DEPTH_X = (ADDR_WID + 1)'(DEPTH);

    state_t              state;
    logic [3:0]          cnt;
    logic                we_q;
    logic [1:0]          size_q;
    logic [ADDR_WID-1:0] addr_q;
    logic [DATA_WID-1:0] wdata_q;
    logic [7:0]          mem [DEPTH];

    logic [3:0]          n_bytes;
    logic [ADDR_WID:0]   end_addr;
    logic                range_err;
    logic                size_err;
    logic                acc_err;
    logic                access_now;
    logic [IDX_WID-1:0]  base_idx;
    logic [7:0]          byte_en;
    logic [63:0]         wdata64;
    logic [63:0]         rd64;

    assign n_bytes    = 4'd1 << size_q;
    // One extra bit keeps addr+n from wrapping near the top of the address space.
    assign end_addr   = {1'b0, addr_q} + {{(ADDR_WID - 3){1'b0}}, n_bytes};
    assign range_err  = end_addr > DEPTH_X;
    assign size_err   = n_bytes > MAX_BYTES;
    assign acc_err    = range_err | size_err;
    assign access_now = (state == BUSY) && (cnt == 4'd0);
    assign base_idx   = addr_q[IDX_WID-1:0];
    assign wdata64    = 64'(wdata_q);

    assign ready      = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign fsm_state  = state;

    always_comb begin
        byte_en = '0;
        rd64    = '0;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < n_bytes) begin
                byte_en[i]     = 1'b1;
                rd64[8*i +: 8] = mem[base_idx + IDX_WID'(i)];
            end
        end
    end

`ifdef DMEM_CLEAR_ON_RESET_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int j = 0; j < DEPTH; j++) mem[j] <= 8'h00;
        end else if (access_now && we_q && !acc_err) begin
            for (int i = 0; i < 8; i++)
                if (byte_en[i]) mem[base_idx + IDX_WID'(i)] <= wdata64[8*i +: 8];
        end
    end
`else
    always_ff @(posedge CLK) begin
        if (access_now && we_q && !acc_err) begin
            for (int i = 0; i < 8; i++)
                if (byte_en[i]) mem[base_idx + IDX_WID'(i)] <= wdata64[8*i +: 8];
        end
    end
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            we_q       <= 1'b0;
            size_q     <= 2'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata      <= '0;
            dmem_error <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        size_q  <= size;
                        addr_q  <= addr;
                        wdata_q <= write_data;
                        cnt     <= 4'(WAIT_CYCLES);
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        dmem_error <= acc_err;
                        rdata      <= (acc_err || we_q) ? '0 : rd64[DATA_WID-1:0];
                        state      <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
